// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for a word-wide data memory.
// Accepts byte/half/word loads and stores at byte addresses, issues word accesses,
// performs read-modify-write for sub-word stores and returns extended load data.
//
// Ports:
//   i_clock, i_reset           clock, asynchronous active-low reset
//   i_valid                    request present (sampled only while o_ready=1)
//   i_mem_read, i_mem_write    load / store request
//   i_size, i_unsigned         access size (00 b, 01 h, 10 w), zero-extend loads
//   i_addr, i_wdata            byte address, right-aligned store data
//   o_ready, o_stall           request accepted this cycle / pipeline freeze
//   o_rdata, o_rvalid          extended load result and its update pulse
//   o_error                    pulse: misaligned or illegal request dropped
//   o_mem_*                    data memory strobes, word address and write word
//   i_mem_rdata                memory read word, valid the cycle after a read
module mem_access_unit #(
  parameter int unsigned NB_DATA  = 32,
  parameter int unsigned NB_ADDR  = 5,
  parameter int unsigned NB_BADDR = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [NB_BADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0]  i_wdata,
  output logic                o_ready,
  output logic                o_stall,
  output logic [NB_DATA-1:0]  o_rdata,
  output logic                o_rvalid,
  output logic                o_error,
  output logic                o_mem_enable,
  output logic                o_mem_write,
  output logic                o_mem_read,
  output logic [NB_ADDR-1:0]  o_mem_addr,
  output logic [NB_DATA-1:0]  o_mem_wdata,
  input  logic [NB_DATA-1:0]  i_mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int unsigned NB_HALF = 16;
  localparam int unsigned NB_BYTE = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           req_size_q;
  logic                 req_unsigned_q;
  logic [1:0]           req_off_q;
  logic [NB_ADDR-1:0]   req_waddr_q;
  logic [NB_HALF-1:0]   req_wdata_q;
  logic [NB_DATA-1:0]   rdata_q;
  logic                 rvalid_q;
  logic                 error_q;

  logic                 accept;
  logic                 legal;
  logic                 latch_req;
  logic                 load_done;
  logic                 error_d;
  logic [4:0]           lane_shamt;
  logic [NB_DATA-1:0]   lane_rdata;
  logic [NB_DATA-1:0]   load_ext;
  logic [NB_DATA-1:0]   lane_mask;
  logic [NB_DATA-1:0]   lane_wdata;
  logic [NB_DATA-1:0]   merged_word;

  // Address bits above the memory word index are intentionally ignored (wrap).
  logic                 unused_addr_hi;
  assign unused_addr_hi = ^i_addr[NB_BADDR-1:NB_ADDR+2];

  // Request qualification in IDLE.
  assign accept = (state_q == ST_IDLE) && i_valid && (i_mem_read || i_mem_write);
  assign legal  = !(i_mem_read && i_mem_write)
               && (i_size != 2'b11)
               && !((i_size == SZ_HALF) && i_addr[0])
               && !((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));

  // Lane extraction and sign/zero extension of the returned word.
  assign lane_shamt = {req_off_q, 3'b000};
  assign lane_rdata = i_mem_rdata >> lane_shamt;

  always_comb begin
    load_ext = i_mem_rdata;
    case (req_size_q)
      SZ_BYTE: load_ext = req_unsigned_q
                        ? {{(NB_DATA-NB_BYTE){1'b0}}, lane_rdata[NB_BYTE-1:0]}
                        : {{(NB_DATA-NB_BYTE){lane_rdata[NB_BYTE-1]}}, lane_rdata[NB_BYTE-1:0]};
      SZ_HALF: load_ext = req_unsigned_q
                        ? {{(NB_DATA-NB_HALF){1'b0}}, lane_rdata[NB_HALF-1:0]}
                        : {{(NB_DATA-NB_HALF){lane_rdata[NB_HALF-1]}}, lane_rdata[NB_HALF-1:0]};
      default: load_ext = i_mem_rdata;
    endcase
  end

  // Merge the latched sub-word store lane into the word read back from memory.
  assign lane_mask   = ((req_size_q == SZ_BYTE) ? NB_DATA'(8'hFF) : NB_DATA'(16'hFFFF)) << lane_shamt;
  assign lane_wdata  = NB_DATA'(req_wdata_q) << lane_shamt;
  assign merged_word = (i_mem_rdata & ~lane_mask) | (lane_wdata & lane_mask);

  // Next-state and memory strobe logic.
  always_comb begin
    state_d      = state_q;
    o_ready      = 1'b0;
    o_mem_enable = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_addr   = i_addr[NB_ADDR+1:2];
    o_mem_wdata  = i_wdata;
    latch_req    = 1'b0;
    load_done    = 1'b0;
    error_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (accept) begin
          if (!legal) begin
            error_d = 1'b1;
          end else begin
            latch_req    = 1'b1;
            o_mem_enable = 1'b1;
            if (i_mem_read) begin
              o_mem_read = 1'b1;
              state_d    = ST_LOAD;
            end else if (i_size == SZ_WORD) begin
              o_mem_write = 1'b1;
            end else begin
              // Sub-word store: fetch the target word first.
              o_mem_read = 1'b1;
              state_d    = ST_RMW;
            end
          end
        end
      end
      ST_LOAD: begin
        load_done = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_RMW: begin
        o_mem_enable = 1'b1;
        o_mem_write  = 1'b1;
        o_mem_addr   = req_waddr_q;
        o_mem_wdata  = merged_word;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_stall = ~o_ready;

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Request latch and registered results.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      req_size_q     <= 2'b00;
      req_unsigned_q <= 1'b0;
      req_off_q      <= 2'b00;
      req_waddr_q    <= '0;
      req_wdata_q    <= '0;
      rdata_q        <= '0;
      rvalid_q       <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      rvalid_q <= load_done;
      error_q  <= error_d;
      if (load_done) rdata_q <= load_ext;
      if (latch_req) begin
        req_size_q     <= i_size;
        req_unsigned_q <= i_unsigned;
        req_off_q      <= i_addr[1:0];
        req_waddr_q    <= i_addr[NB_ADDR+1:2];
        req_wdata_q    <= i_wdata[NB_HALF-1:0];
      end
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_error  = error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit with a behavioural
// word memory and a byte-level reference model of memory contents and load results.
module tb_mem_access_unit;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic        i_unsigned = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_ready, o_stall, o_rvalid, o_error;
  logic        o_mem_enable, o_mem_write, o_mem_read;
  logic [31:0] o_rdata, o_mem_wdata;
  logic [4:0]  o_mem_addr;
  logic [31:0] i_mem_rdata = '0;

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  logic [31:0] exp_rdata = '0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clock = ~i_clock;

  mem_access_unit dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ready(o_ready), .o_stall(o_stall), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
    .o_error(o_error), .o_mem_enable(o_mem_enable), .o_mem_write(o_mem_write),
    .o_mem_read(o_mem_read), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  // Synchronous word memory: read data appears the cycle after the read strobe.
  always @(posedge i_clock) begin
    if (o_mem_enable) begin
      if (o_mem_write) mem[o_mem_addr] <= o_mem_wdata;
      if (o_mem_read)  i_mem_rdata <= mem[o_mem_addr];
    end
  end

  function automatic bit model_legal(input logic rd, wr, input logic [1:0] sz, input logic [31:0] a);
    if (rd && wr) return 0;
    if (sz == 2'd3) return 0;
    if (sz == 2'd1 && (a % 2) != 0) return 0;
    if (sz == 2'd2 && (a % 4) != 0) return 0;
    return 1;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] w, v;
    int off, n;
    w = ref_mem[(a / 4) % 32];
    off = a % 4;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v + ((w >> (8 * (off + i))) & 32'hFF) * (32'd1 << (8 * i));
    if (!uns && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v + (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int idx, off;
    logic [31:0] w;
    idx = (a / 4) % 32;
    off = a % 4;
    w = ref_mem[idx];
    for (int i = 0; i < nbytes(sz); i++) w[8 * (off + i) +: 8] = wd[8 * i +: 8];
    ref_mem[idx] = w;
  endtask

  // Drives one request and records what the DUT does over the accept cycle plus 3.
  task automatic drive_req(input logic rd, wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, wd, output int en_cnt, wr_cnt, stall_cnt,
                           rv_idx, er_idx, output logic [31:0] rdata, output logic [4:0] addr0);
    int guard;
    guard = 0; en_cnt = 0; wr_cnt = 0; stall_cnt = 0; rv_idx = -1; er_idx = -1;
    @(negedge i_clock);
    while (!o_ready && guard < 8) begin @(negedge i_clock); guard++; end
    n_tests++;
    if (!o_ready) begin n_fail++; $display("FAIL ready_timeout: o_ready=%0b required 1", o_ready); end
    i_valid = 1; i_mem_read = rd; i_mem_write = wr; i_size = sz; i_unsigned = uns;
    i_addr = a; i_wdata = wd;
    #1;
    if (o_mem_enable) en_cnt++;
    if (o_mem_enable && o_mem_write) wr_cnt++;
    addr0 = o_mem_addr;
    @(posedge i_clock); #1;
    i_valid = 0; i_mem_read = 0; i_mem_write = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clock);
      if (o_stall) stall_cnt++;
      if (o_mem_enable) en_cnt++;
      if (o_mem_enable && o_mem_write) wr_cnt++;
      if (o_rvalid) rv_idx = k;
      if (o_error) er_idx = k;
    end
    rdata = o_rdata;
  endtask

  task automatic test_reset();
    i_reset = 0;
    #2;
    n_tests++;
    if (o_ready !== 1'b1 || o_rdata !== 32'h0 || o_rvalid !== 1'b0 || o_error !== 1'b0 || o_mem_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%0b rdata=%h rvalid=%0b error=%0b en=%0b required 1/0/0/0/0",
               o_ready, o_rdata, o_rvalid, o_error, o_mem_enable);
    end
    @(negedge i_clock); i_reset = 1;
    exp_rdata = 0;
  endtask

  task automatic test_word_store_load();
    int en, wrc, st, rv, er; logic [31:0] rd; logic [4:0] a0;
    drive_req(0, 1, 2'd2, 0, 32'h08, 32'hDEADBEEF, en, wrc, st, rv, er, rd, a0);
    model_store(2'd2, 32'h08, 32'hDEADBEEF);
    n_tests++;
    if (en != 1 || wrc != 1 || st != 0 || a0 !== 5'd2) begin
      n_fail++; $display("FAIL sw_issue: en=%0d wr=%0d stall=%0d addr=%0d required 1/1/0/2", en, wrc, st, a0);
    end
    drive_req(1, 0, 2'd2, 0, 32'h08, 32'h0, en, wrc, st, rv, er, rd, a0);
    exp_rdata = 32'hDEADBEEF;
    n_tests++;
    if (rd !== 32'hDEADBEEF || rv != 2 || st != 1 || a0 !== 5'd2 || en != 1 || wrc != 0) begin
      n_fail++; $display("FAIL lw_basic: rdata=%h rv_idx=%0d stall=%0d addr=%0d en=%0d required deadbeef/2/1/2/1",
                         rd, rv, st, a0, en);
    end
  endtask

  task automatic test_sub_loads();
    int en, wrc, st, rv, er; logic [31:0] rd; logic [4:0] a0;
    logic [1:0]  szs [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ads [4] = '{32'h04, 32'h04, 32'h06, 32'h06};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000};
    drive_req(0, 1, 2'd2, 0, 32'h04, 32'h80007F80, en, wrc, st, rv, er, rd, a0);
    model_store(2'd2, 32'h04, 32'h80007F80);
    for (int i = 0; i < 4; i++) begin
      drive_req(1, 0, szs[i], uns[i], ads[i], 32'h0, en, wrc, st, rv, er, rd, a0);
      exp_rdata = exp[i];
      n_tests++;
      if (rd !== exp[i] || rv != 2 || st != 1) begin
        n_fail++; $display("FAIL sub_load%0d: rdata=%h rv_idx=%0d stall=%0d required %h/2/1", i, rd, rv, st, exp[i]);
      end
    end
  endtask

  task automatic test_sub_stores();
    int en, wrc, st, rv, er; logic [31:0] rd; logic [4:0] a0;
    drive_req(0, 1, 2'd2, 0, 32'h0C, 32'h11223344, en, wrc, st, rv, er, rd, a0);
    model_store(2'd2, 32'h0C, 32'h11223344);
    drive_req(0, 1, 2'd0, 0, 32'h0D, 32'h000000AA, en, wrc, st, rv, er, rd, a0);
    model_store(2'd0, 32'h0D, 32'h000000AA);
    n_tests++;
    if (mem[3] !== 32'h1122AA44 || st != 1 || en != 2 || wrc != 1) begin
      n_fail++; $display("FAIL sb_rmw: mem3=%h stall=%0d en=%0d wr=%0d required 1122aa44/1/2/1", mem[3], st, en, wrc);
    end
    drive_req(0, 1, 2'd1, 0, 32'h0E, 32'h0000BEEF, en, wrc, st, rv, er, rd, a0);
    model_store(2'd1, 32'h0E, 32'h0000BEEF);
    n_tests++;
    if (mem[3] !== 32'hBEEFAA44 || st != 1 || en != 2 || wrc != 1) begin
      n_fail++; $display("FAIL sh_rmw: mem3=%h stall=%0d en=%0d wr=%0d required beefaa44/1/2/1", mem[3], st, en, wrc);
    end
  endtask

  task automatic test_illegal();
    int en, wrc, st, rv, er; logic [31:0] rd; logic [4:0] a0;
    logic        rds [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        wrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  szs [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic [31:0] ads [4] = '{32'h06, 32'h03, 32'h04, 32'h04};
    for (int i = 0; i < 4; i++) begin
      drive_req(rds[i], wrs[i], szs[i], 0, ads[i], 32'hFFFF_FFFF, en, wrc, st, rv, er, rd, a0);
      n_tests++;
      if (en != 0 || er != 1 || st != 0 || rv != -1 || mem[0] !== ref_mem[0] || mem[1] !== ref_mem[1]) begin
        n_fail++; $display("FAIL illegal%0d: en=%0d er_idx=%0d stall=%0d rv_idx=%0d mem1=%h required 0/1/0/-1/%h",
                           i, en, er, st, rv, mem[1], ref_mem[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int en, wrc, st, rv, er; logic [31:0] rd; logic [4:0] a0; logic [31:0] v;
    v = $urandom;
    @(negedge i_clock);
    i_valid = 1; i_mem_write = 1; i_mem_read = 0; i_size = 2'd2; i_addr = 32'h14; i_wdata = v;
    @(posedge i_clock); #1;
    model_store(2'd2, 32'h14, v);
    i_mem_write = 0; i_mem_read = 1; i_unsigned = 0;
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_sw_ready: o_ready=%0b required 1", o_ready); end
    @(posedge i_clock); #1;
    i_valid = 0; i_mem_read = 0;
    @(posedge i_clock); #1;
    exp_rdata = v;
    n_tests++;
    if (o_rvalid !== 1'b1 || o_rdata !== v) begin
      n_fail++; $display("FAIL b2b_sw_lw: rvalid=%0b rdata=%h required 1/%h", o_rvalid, o_rdata, v);
    end
    i_valid = 1; i_mem_write = 1; i_size = 2'd0; i_addr = 32'h15; i_wdata = 32'h0000_00C3;
    @(posedge i_clock); #1;
    model_store(2'd0, 32'h15, 32'h0000_00C3);
    i_valid = 0; i_mem_write = 0;
    n_tests++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_rmw_busy: o_ready=%0b required 0", o_ready); end
    @(posedge i_clock); #1;
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rmw_ready: o_ready=%0b required 1", o_ready); end
    i_valid = 1; i_mem_read = 1; i_size = 2'd0; i_unsigned = 0; i_addr = 32'h15;
    @(posedge i_clock); #1;
    i_valid = 0; i_mem_read = 0;
    @(posedge i_clock); #1;
    exp_rdata = model_load(2'd0, 0, 32'h15);
    n_tests++;
    if (o_rvalid !== 1'b1 || o_rdata !== 32'hFFFF_FFC3) begin
      n_fail++; $display("FAIL b2b_sb_lb: rvalid=%0b rdata=%h required 1/ffffffc3", o_rvalid, o_rdata);
    end
    drive_req(0, 0, 2'd2, 0, 32'h0, 32'h0, en, wrc, st, rv, er, rd, a0);
  endtask

  task automatic test_reset_mid_rmw();
    int en, wrc, st, rv, er; logic [31:0] rd; logic [4:0] a0;
    drive_req(0, 1, 2'd2, 0, 32'h10, 32'h0BADF00D, en, wrc, st, rv, er, rd, a0);
    model_store(2'd2, 32'h10, 32'h0BADF00D);
    drive_req(1, 0, 2'd2, 0, 32'h10, 32'h0, en, wrc, st, rv, er, rd, a0);
    @(negedge i_clock);
    i_valid = 1; i_mem_write = 1; i_size = 2'd0; i_addr = 32'h10; i_wdata = 32'h55;
    @(posedge i_clock); #1;
    i_valid = 0; i_mem_write = 0;
    n_tests++;
    if (o_mem_write !== 1'b1) begin n_fail++; $display("FAIL rmw_pending: o_mem_write=%0b required 1", o_mem_write); end
    #2 i_reset = 0;
    #1;
    n_tests++;
    if (o_ready !== 1'b1 || o_stall !== 1'b0 || o_mem_enable !== 1'b0 || o_rdata !== 32'h0 || o_rvalid !== 1'b0 || o_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_rmw: ready=%0b stall=%0b en=%0b rdata=%h rvalid=%0b error=%0b required 1/0/0/0/0/0",
                         o_ready, o_stall, o_mem_enable, o_rdata, o_rvalid, o_error);
    end
    @(posedge i_clock); #1;
    @(negedge i_clock); i_reset = 1;
    exp_rdata = 0;
    n_tests++;
    if (mem[4] !== 32'h0BADF00D) begin n_fail++; $display("FAIL reset_no_write: mem4=%h required 0badf00d", mem[4]); end
  endtask

  task automatic test_wrap();
    int en, wrc, st, rv, er; logic [31:0] rd; logic [4:0] a0;
    drive_req(0, 1, 2'd2, 0, 32'h80, 32'h12345678, en, wrc, st, rv, er, rd, a0);
    model_store(2'd2, 32'h80, 32'h12345678);
    n_tests++;
    if (a0 !== 5'd0 || mem[0] !== 32'h12345678) begin
      n_fail++; $display("FAIL wrap_sw: addr=%0d mem0=%h required 0/12345678", a0, mem[0]);
    end
    drive_req(1, 0, 2'd2, 0, 32'h00, 32'h0, en, wrc, st, rv, er, rd, a0);
    exp_rdata = 32'h12345678;
    n_tests++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL wrap_lw: rdata=%h required 12345678", rd); end
  endtask

  task automatic test_random();
    int en, wrc, st, rv, er; logic [31:0] rd; logic [4:0] a0;
    logic r, w, u; logic [1:0] sz; logic [31:0] a, wd;
    int x_en, x_wr, x_st, x_rv, x_er;
    for (int i = 0; i < 32; i++) begin
      wd = $urandom;
      drive_req(0, 1, 2'd2, 0, 32'(i * 4), wd, en, wrc, st, rv, er, rd, a0);
      model_store(2'd2, 32'(i * 4), wd);
    end
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       begin r = 1; w = 1; end
        1:       begin r = 0; w = 0; end
        2, 3, 4, 5: begin r = 1; w = 0; end
        default: begin r = 0; w = 1; end
      endcase
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      u = 1'($urandom);
      a = $urandom & 32'h1FF;
      wd = $urandom;
      x_en = 0; x_wr = 0; x_st = 0; x_rv = -1; x_er = -1;
      if (r || w) begin
        if (!model_legal(r, w, sz, a)) x_er = 1;
        else if (r) begin x_en = 1; x_st = 1; x_rv = 2; exp_rdata = model_load(sz, u, a); end
        else if (sz == 2'd2) begin x_en = 1; x_wr = 1; end
        else begin x_en = 2; x_wr = 1; x_st = 1; end
      end
      drive_req(r, w, sz, u, a, wd, en, wrc, st, rv, er, rd, a0);
      if (w && !r && model_legal(r, w, sz, a)) model_store(sz, a, wd);
      n_tests++;
      if (en != x_en || wrc != x_wr || st != x_st || rv != x_rv || er != x_er || rd !== exp_rdata) begin
        n_fail++;
        $display("FAIL rand%0d r%0b w%0b sz%0d a=%h: en=%0d wr=%0d st=%0d rv=%0d er=%0d rdata=%h required %0d/%0d/%0d/%0d/%0d/%h",
                 i, r, w, sz, a, en, wrc, st, rv, er, rd, x_en, x_wr, x_st, x_rv, x_er, exp_rdata);
      end
    end
    for (int i = 0; i < 32; i++) begin
      n_tests++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL mem_final[%0d]: %h required %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_word_store_load();
    test_sub_loads();
    test_sub_stores();
    test_illegal();
    test_back_to_back();
    test_reset_mid_rmw();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
